sram_fault_model: RTL

Behavioural 256x4 single-port SRAM that answers the March C MBIST controller on its address, data, write-enable and read-data bus. It holds a programmable four-entry fault table so a bench can plant stuck-at, transition and coupling faults and check that the controller detects them. It replaces the plain SRAM in MBIST benches and keeps the same bus ports and timing.

---
 rtl/sram_fault_pkg.sv | 23 ++
 rtl/fault_slot.sv | 65 ++++++
 rtl/sram_fault_model.sv | 119 +++++++++++
 3 files changed

// File: rtl/sram_fault_pkg.sv
// Shared constants, fault type codes and the fault-table entry layout
// for the fault-injecting SRAM model.
package sram_fault_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 4;
    localparam int N_FAULT_DEF = 4;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] SA0  = 3'd1;
    localparam logic [2:0] SA1  = 3'd2;
    localparam logic [2:0] TFU  = 3'd3;
    localparam logic [2:0] TFD  = 3'd4;
    localparam logic [2:0] CFIN = 3'd5;

    typedef struct packed {
        logic [2:0]            ftype;
        logic [ADDR_W_DEF-1:0] victim;
        logic [1:0]            bit_sel;
        logic [ADDR_W_DEF-1:0] aggr;
    } fault_entry_t;

endpackage

// File: rtl/fault_slot.sv
// One fault-table entry: holds the programmed fault and reports, for the
// current access, which bits it forces, keeps or inverts.
module fault_slot
    import sram_fault_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_type,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_bit,
    input  logic [ADDR_W-1:0] cfg_aggr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              w_en,
    input  logic [DATA_W-1:0] dat_in,
    input  logic [DATA_W-1:0] old_word,
    output logic              victim_hit,
    output logic              aggr_hit,
    output logic [DATA_W-1:0] force0,
    output logic [DATA_W-1:0] force1,
    output logic [DATA_W-1:0] keep,
    output logic [DATA_W-1:0] invert,
    output logic [ADDR_W-1:0] victim_addr
);

    fault_entry_t entry;
    logic [DATA_W-1:0] mask;
    logic old_bit;
    logic new_bit;
    logic cell_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry <= '0;
        end else if (cfg_we) begin
            entry <= '{ftype: cfg_type, victim: cfg_addr, bit_sel: cfg_bit, aggr: cfg_aggr};
        end
    end

    always_comb begin
        mask        = DATA_W'(1) << entry.bit_sel;
        old_bit     = old_word[entry.bit_sel];
        new_bit     = dat_in[entry.bit_sel];
        victim_addr = entry.victim;
        cell_fault  = (entry.ftype == SA0) || (entry.ftype == SA1) ||
                      (entry.ftype == TFU) || (entry.ftype == TFD);
        victim_hit  = cell_fault && (addr_in == entry.victim);
        // A coupling fault whose aggressor is its own victim is inert.
        aggr_hit    = (entry.ftype == CFIN) && (entry.aggr != entry.victim) &&
                      (addr_in == entry.aggr);
        force0 = (victim_hit && entry.ftype == SA0) ? mask : '0;
        force1 = (victim_hit && entry.ftype == SA1) ? mask : '0;
        keep   = '0;
        if (w_en && victim_hit &&
            ((entry.ftype == TFU && !old_bit && new_bit) ||
             (entry.ftype == TFD && old_bit && !new_bit))) begin
            keep = mask;
        end
        invert = (w_en && aggr_hit && !old_bit && new_bit) ? mask : '0;
    end

endmodule

// File: rtl/sram_fault_model.sv
// Behavioural single-port SRAM with a programmable fault table, used in
// place of the plain SRAM to exercise the March C MBIST controller.
module sram_fault_model
    import sram_fault_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int N_FAULT = N_FAULT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] dat_in,
    input  logic              w_en,
    output logic [DATA_W-1:0] read_d,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_idx,
    input  logic [2:0]        cfg_type,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_bit,
    input  logic [ADDR_W-1:0] cfg_aggr,
    output logic [7:0]        hit_cnt
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] old_word;

    logic              victim_hit  [N_FAULT];
    logic              aggr_hit    [N_FAULT];
    logic [DATA_W-1:0] force0      [N_FAULT];
    logic [DATA_W-1:0] force1      [N_FAULT];
    logic [DATA_W-1:0] keep        [N_FAULT];
    logic [DATA_W-1:0] invert      [N_FAULT];
    logic [ADDR_W-1:0] victim_addr [N_FAULT];
    logic [DATA_W-1:0] inv_acc     [N_FAULT];

    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;
    logic              rd_stuck;
    logic              any_inv;
    logic              hit;

    assign old_word = mem[addr_in];

    for (genvar i = 0; i < N_FAULT; i++) begin : g_slot
        fault_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .cfg_we     (cfg_we && (cfg_idx == 2'(i))),
            .cfg_type   (cfg_type),
            .cfg_addr   (cfg_addr),
            .cfg_bit    (cfg_bit),
            .cfg_aggr   (cfg_aggr),
            .addr_in    (addr_in),
            .w_en       (w_en),
            .dat_in     (dat_in),
            .old_word   (old_word),
            .victim_hit (victim_hit[i]),
            .aggr_hit   (aggr_hit[i]),
            .force0     (force0[i]),
            .force1     (force1[i]),
            .keep       (keep[i]),
            .invert     (invert[i]),
            .victim_addr(victim_addr[i])
        );
    end

    // Masks are applied in ascending index order so the highest index wins.
    always_comb begin
        wr_word  = dat_in;
        rd_word  = old_word;
        rd_stuck = 1'b0;
        any_inv  = 1'b0;
        for (int i = 0; i < N_FAULT; i++) begin
            wr_word  = (wr_word & ~force0[i]) | force1[i];
            wr_word  = (wr_word & ~keep[i]) | (old_word & keep[i]);
            rd_word  = (rd_word & ~force0[i]) | force1[i];
            rd_stuck = rd_stuck || (victim_hit[i] && |(force0[i] | force1[i]));
            any_inv  = any_inv || (aggr_hit[i] && |invert[i]);
        end
        // Entries sharing a victim fold their inversions so every write agrees.
        for (int i = 0; i < N_FAULT; i++) begin
            inv_acc[i] = '0;
            for (int j = 0; j < N_FAULT; j++) begin
                if (victim_addr[j] == victim_addr[i]) begin
                    inv_acc[i] = inv_acc[i] ^ invert[j];
                end
            end
        end
        // A stuck cell counts on every read: a fault-free cell could hold any value.
        hit = w_en ? ((wr_word != dat_in) || any_inv) : rd_stuck;
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[addr_in] <= wr_word;
        end
        for (int i = 0; i < N_FAULT; i++) begin
            if (|inv_acc[i]) begin
                mem[victim_addr[i]] <= mem[victim_addr[i]] ^ inv_acc[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_d  <= '0;
            hit_cnt <= '0;
        end else begin
            if (!w_en) begin
                read_d <= rd_word;
            end
            if (hit && (hit_cnt != 8'hFF)) begin
                hit_cnt <= hit_cnt + 8'd1;
            end
        end
    end

endmodule
